ins_mem_loader: RTL and testbench

- Sequences programming of the instruction memory from a byte stream, e.g. UART RX or a debug port.
- Receives a 16-bit word count, then that many 32-bit little-endian instructions.
- Issues one write per instruction at consecutive word-aligned byte addresses.
- Holds the processor in reset while loading and releases it once the program is complete.

---
 rtl/ins_loader_pkg.sv | 21 ++
 rtl/ins_mem_loader_packer.sv | 52 +++++
 rtl/ins_mem_loader.sv | 169 ++++++++++++++++
 tb/tb_ins_mem_loader.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ins_loader_pkg.sv
// ---------------------------------------------------------------------------
// ins_loader_pkg
// Shared types and constants for the instruction-memory loader.
//   loader_state_t : loader FSM states
//   BYTES_PER_WORD : bytes in one instruction word
//   LEN_BYTES      : bytes in the word-count header
// ---------------------------------------------------------------------------
package ins_loader_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LEN,
    WORD,
    WRITE,
    FINISH
  } loader_state_t;

  localparam int BYTES_PER_WORD = 4;
  localparam int LEN_BYTES      = 2;

endpackage

// File: rtl/ins_mem_loader_packer.sv
// ---------------------------------------------------------------------------
// byte_to_word_packer
// Assembles little-endian bytes into one instruction word. Byte k of a word
// lands in bits [8k+7:8k].
//   clk, rst_n    : clock, asynchronous active-low reset
//   clear_i       : restart the byte counter (new session)
//   valid_i       : a byte is consumed this cycle
//   byte_i        : the byte being consumed
//   word_valid_o  : this byte completes a word (combinational)
//   word_o        : the word including the byte being consumed
// ---------------------------------------------------------------------------
module byte_to_word_packer
  import ins_loader_pkg::*;
(
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        clear_i,
  input  logic                        valid_i,
  input  logic [7:0]                  byte_i,
  output logic                        word_valid_o,
  output logic [8*BYTES_PER_WORD-1:0] word_o
);

  localparam int WORD_W = 8 * BYTES_PER_WORD;
  localparam int CNT_W  = $clog2(BYTES_PER_WORD);

  logic [CNT_W-1:0]  cnt_q;
  logic [WORD_W-1:0] word_q;

  // Shifting in from the top leaves the first byte in the lowest lane once
  // the word is complete. Exposing the next value lets the FSM capture the
  // finished word on the same edge that consumes its last byte.
  assign word_o       = {byte_i, word_q[WORD_W-1:8]};
  assign word_valid_o = valid_i && (cnt_q == CNT_W'(BYTES_PER_WORD - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: the shift register is a handful of flops, so it is reset along
    // with the counter; nothing here is a RAM that would forbid a reset.
    if (!rst_n) begin
      cnt_q  <= '0;
      word_q <= '0;
    end else if (clear_i) begin
      cnt_q <= '0;
    end else if (valid_i) begin
      // NOTE: non-blocking assignments in clocked blocks so every flop sees
      // the pre-edge values of the others, whatever the statement order.
      cnt_q  <= cnt_q + 1'b1;  // wraps to 0 exactly at word completion
      word_q <= word_o;
    end
  end

endmodule

// File: rtl/ins_mem_loader.sv
// ---------------------------------------------------------------------------
// ins_mem_loader
// Programs the instruction memory from a byte stream: a 16-bit little-endian
// word count, then that many 32-bit little-endian instructions, written at
// consecutive word-aligned byte addresses. The processor is held in reset
// for the duration of the load.
//   clk, rstN     : clock, asynchronous active-low reset
//   start         : single-cycle request to begin a session (ignored if busy)
//   byte_valid/byte_data/byte_ready : valid/ready byte input
//   mem_wr_en/mem_wr_addr/mem_wr_data : one write per instruction
//   busy          : session in progress
//   done          : one-cycle pulse on successful completion
//   error         : sticky bad word count, cleared by the next start
//   cpu_rstN      : active-low processor reset, low while loading
// ---------------------------------------------------------------------------
module ins_mem_loader
  import ins_loader_pkg::*;
#(
  parameter int INSTRUCTION_WIDTH = 32,
  parameter int MEMORY_DEPTH      = 256,
  parameter int PC_WIDTH          = 32
) (
  input  logic                         clk,
  input  logic                         rstN,
  input  logic                         start,
  input  logic                         byte_valid,
  input  logic [7:0]                   byte_data,
  output logic                         byte_ready,
  output logic                         mem_wr_en,
  output logic [PC_WIDTH-1:0]          mem_wr_addr,
  output logic [INSTRUCTION_WIDTH-1:0] mem_wr_data,
  output logic                         busy,
  output logic                         done,
  output logic                         error,
  output logic                         cpu_rstN
);

  localparam int          IDX_W    = $clog2(MEMORY_DEPTH) + 1;
  localparam logic [15:0] DEPTH_16 = 16'(MEMORY_DEPTH);

  loader_state_t               state_q;
  logic [7:0]                  len_lo_q;
  logic [15:0]                 len_q;
  logic [0:0]                  len_cnt_q;
  logic [IDX_W-1:0]            word_idx_q;
  logic                        byte_ready_q;
  logic                        mem_wr_en_q;
  logic [PC_WIDTH-1:0]         mem_wr_addr_q;
  logic [INSTRUCTION_WIDTH-1:0] mem_wr_data_q;
  logic                        busy_q;
  logic                        done_q;
  logic                        error_q;
  logic                        cpu_rstN_q;

  logic                        transfer;
  logic                        word_valid;
  logic [8*BYTES_PER_WORD-1:0] packed_word;
  logic [15:0]                 len_rx;
  logic [15:0]                 idx_next16;

  assign transfer   = byte_valid & byte_ready_q;
  assign len_rx     = {byte_data, len_lo_q};
  assign idx_next16 = 16'(word_idx_q) + 16'd1;

  byte_to_word_packer u_packer (
    .clk          (clk),
    .rst_n        (rstN),
    .clear_i      (start && (state_q == IDLE)),
    .valid_i      (transfer && (state_q == WORD)),
    .byte_i       (byte_data),
    .word_valid_o (word_valid),
    .word_o       (packed_word)
  );

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      state_q       <= IDLE;
      len_lo_q      <= '0;
      len_q         <= '0;
      len_cnt_q     <= '0;
      word_idx_q    <= '0;
      byte_ready_q  <= 1'b0;
      mem_wr_en_q   <= 1'b0;
      mem_wr_addr_q <= '0;
      mem_wr_data_q <= '0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      error_q       <= 1'b0;
      cpu_rstN_q    <= 1'b1;
    end else begin
      // Strobes default low; the states below raise them for one cycle.
      mem_wr_en_q <= 1'b0;
      done_q      <= 1'b0;

      unique case (state_q)
        IDLE: begin
          if (start) begin
            state_q      <= LEN;
            error_q      <= 1'b0;
            word_idx_q   <= '0;
            len_cnt_q    <= '0;
            cpu_rstN_q   <= 1'b0;
            busy_q       <= 1'b1;
            byte_ready_q <= 1'b1;
          end
        end

        LEN: begin
          if (transfer) begin
            if (len_cnt_q != 1'(LEN_BYTES - 1)) begin
              len_lo_q  <= byte_data;
              len_cnt_q <= len_cnt_q + 1'b1;
            end else if (len_rx == 16'd0 || len_rx > DEPTH_16) begin
              // Bad count: abandon without touching memory and let the
              // processor run its existing image again.
              state_q      <= IDLE;
              error_q      <= 1'b1;
              busy_q       <= 1'b0;
              cpu_rstN_q   <= 1'b1;
              byte_ready_q <= 1'b0;
            end else begin
              state_q <= WORD;
              len_q   <= len_rx;
            end
          end
        end

        WORD: begin
          if (word_valid) begin
            state_q       <= WRITE;
            byte_ready_q  <= 1'b0;
            mem_wr_en_q   <= 1'b1;
            mem_wr_addr_q <= PC_WIDTH'({word_idx_q, 2'b00});
            mem_wr_data_q <= INSTRUCTION_WIDTH'(packed_word);
          end
        end

        WRITE: begin
          word_idx_q <= word_idx_q + 1'b1;
          if (idx_next16 == len_q) begin
            state_q    <= FINISH;
            done_q     <= 1'b1;
            cpu_rstN_q <= 1'b1;
          end else begin
            state_q      <= WORD;
            byte_ready_q <= 1'b1;
          end
        end

        FINISH: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end

        default: state_q <= IDLE;
      endcase
    end
  end

  assign byte_ready  = byte_ready_q;
  assign mem_wr_en   = mem_wr_en_q;
  assign mem_wr_addr = mem_wr_addr_q;
  assign mem_wr_data = mem_wr_data_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign error       = error_q;
  assign cpu_rstN    = cpu_rstN_q;

endmodule

// File: tb/tb_ins_mem_loader.sv
// ---------------------------------------------------------------------------
// tb_ins_mem_loader
// Directed bench for ins_mem_loader: reset, normal and stalled loads, bad
// word counts, a full-depth load, reset mid-word and start while busy.
// ---------------------------------------------------------------------------
module tb_ins_mem_loader;

  localparam int DEPTH = 256;

  logic        clk = 1'b0;
  logic        rstN;
  logic        start;
  logic        byte_valid;
  logic [7:0]  byte_data;
  logic        byte_ready;
  logic        mem_wr_en;
  logic [31:0] mem_wr_addr;
  logic [31:0] mem_wr_data;
  logic        busy;
  logic        done;
  logic        error;
  logic        cpu_rstN;

  always #5 clk = ~clk;

  ins_mem_loader #(
    .INSTRUCTION_WIDTH (32),
    .MEMORY_DEPTH      (DEPTH),
    .PC_WIDTH          (32)
  ) dut (
    .clk         (clk),
    .rstN        (rstN),
    .start       (start),
    .byte_valid  (byte_valid),
    .byte_data   (byte_data),
    .byte_ready  (byte_ready),
    .mem_wr_en   (mem_wr_en),
    .mem_wr_addr (mem_wr_addr),
    .mem_wr_data (mem_wr_data),
    .busy        (busy),
    .done        (done),
    .error       (error),
    .cpu_rstN    (cpu_rstN)
  );

  int n_checks = 0;
  int n_pass   = 0;

  // Write/done log, sampled mid-cycle.
  logic [31:0] wr_addr_log[$];
  logic [31:0] wr_data_log[$];
  int          done_cnt   = 0;
  int          cpu_viol   = 0;
  int          ready_viol = 0;

  always @(negedge clk) begin
    if (mem_wr_en === 1'b1) begin
      wr_addr_log.push_back(mem_wr_addr);
      wr_data_log.push_back(mem_wr_data);
      if (cpu_rstN !== 1'b0) cpu_viol++;
      if (byte_ready !== 1'b0) ready_viol++;
    end
    if (done === 1'b1) begin
      done_cnt++;
      if (cpu_rstN !== 1'b1) cpu_viol++;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass = n_pass + 1;
    else $error("FAIL %s: observed 0x%08h, expected 0x%08h", tag, obs, exp);
  endtask

  // Offers one byte from a negedge and returns at the negedge after it was
  // consumed; with stall set, a random idle cycle may precede it.
  task automatic send_byte(input logic [7:0] b, input bit stall);
    int waited = 0;
    if (stall && ($urandom_range(1, 0) == 1)) begin
      byte_valid = 1'b0;
      @(negedge clk);
    end
    byte_valid = 1'b1;
    byte_data  = b;
    while (byte_ready !== 1'b1 && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    @(negedge clk);
    byte_valid = 1'b0;
    check("byte_accept", 32'(waited < 50), 32'd1);
  endtask

  task automatic send_word(input logic [31:0] w, input bit stall);
    logic [31:0] v;
    v = w;
    for (int k = 0; k < 4; k++) send_byte(v[8*k +: 8], stall);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while (busy !== 1'b0 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    check(tag, 32'(busy), 32'd0);
    @(negedge clk);
  endtask

  initial begin
    logic [7:0]  prog[10];
    logic [31:0] exp_words[DEPTH];
    int base;
    int done_base;
    int mism;

    prog = '{8'h02, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00};

    rstN = 1'b0; start = 1'b0; byte_valid = 1'b0; byte_data = 8'h00;
    repeat (2) @(negedge clk);

    // ---- reset values ----
    check("rst_byte_ready", 32'(byte_ready), 32'd0);
    check("rst_wr_en",      32'(mem_wr_en),  32'd0);
    check("rst_busy",       32'(busy),       32'd0);
    check("rst_done",       32'(done),       32'd0);
    check("rst_error",      32'(error),      32'd0);
    check("rst_addr",       mem_wr_addr,     32'h0);
    check("rst_data",       mem_wr_data,     32'h0);
    check("rst_cpu_rstN",   32'(cpu_rstN),   32'd1);
    rstN = 1'b1;

    // ---- idle ignores offered bytes ----
    byte_valid = 1'b1; byte_data = 8'hA5;
    repeat (5) @(negedge clk);
    check("idle_no_ready",  32'(byte_ready), 32'd0);
    check("idle_no_writes", 32'(wr_addr_log.size()), 32'd0);
    byte_valid = 1'b0;

    // ---- normal load, exact cycle timing ----
    base = wr_addr_log.size(); done_base = done_cnt;
    pulse_start();
    check("start_busy",     32'(busy),       32'd1);
    check("start_cpu_rstN", 32'(cpu_rstN),   32'd0);
    check("start_ready",    32'(byte_ready), 32'd1);
    for (int i = 0; i < 6; i++) send_byte(prog[i], 1'b0);
    check("w0_wr_en",  32'(mem_wr_en),  32'd1);
    check("w0_addr",   mem_wr_addr,     32'h0);
    check("w0_data",   mem_wr_data,     32'h0000_0013);
    check("w0_ready",  32'(byte_ready), 32'd0);
    for (int i = 6; i < 10; i++) send_byte(prog[i], 1'b0);
    check("w1_wr_en",  32'(mem_wr_en),  32'd1);
    check("w1_addr",   mem_wr_addr,     32'h4);
    check("w1_data",   mem_wr_data,     32'h0010_0093);
    check("w1_cpu_rstN", 32'(cpu_rstN), 32'd0);
    check("w1_no_done",  32'(done),     32'd0);
    @(negedge clk);
    check("fin_done",     32'(done),      32'd1);
    check("fin_cpu_rstN", 32'(cpu_rstN),  32'd1);
    check("fin_busy",     32'(busy),      32'd1);
    check("fin_wr_en",    32'(mem_wr_en), 32'd0);
    @(negedge clk);
    check("idle_busy",    32'(busy),      32'd0);
    check("idle_done",    32'(done),      32'd0);
    check("idle_addr_hold", mem_wr_addr,  32'h4);
    check("idle_data_hold", mem_wr_data,  32'h0010_0093);
    check("norm_wr_count",  32'(wr_addr_log.size() - base), 32'd2);
    check("norm_done_once", 32'(done_cnt - done_base),      32'd1);

    // ---- stalled upstream, same stream ----
    base = wr_addr_log.size(); done_base = done_cnt;
    pulse_start();
    for (int i = 0; i < 10; i++) send_byte(prog[i], 1'b1);
    wait_idle("stall_idle");
    check("stall_wr_count", 32'(wr_addr_log.size() - base), 32'd2);
    check("stall_addr0", wr_addr_log[base],     32'h0);
    check("stall_data0", wr_data_log[base],     32'h0000_0013);
    check("stall_addr1", wr_addr_log[base + 1], 32'h4);
    check("stall_data1", wr_data_log[base + 1], 32'h0010_0093);
    check("stall_done_once", 32'(done_cnt - done_base), 32'd1);

    // ---- length zero ----
    base = wr_addr_log.size();
    pulse_start();
    send_byte(8'h00, 1'b0);
    send_byte(8'h00, 1'b0);
    check("len0_error",    32'(error),      32'd1);
    check("len0_busy",     32'(busy),       32'd0);
    check("len0_cpu_rstN", 32'(cpu_rstN),   32'd1);
    check("len0_ready",    32'(byte_ready), 32'd0);
    repeat (3) @(negedge clk);
    check("len0_no_writes", 32'(wr_addr_log.size() - base), 32'd0);

    // ---- length 257 (one past depth) ----
    pulse_start();
    check("start_clears_err", 32'(error), 32'd0);
    send_byte(8'h01, 1'b0);
    send_byte(8'h01, 1'b0);
    check("len257_error",    32'(error),    32'd1);
    check("len257_cpu_rstN", 32'(cpu_rstN), 32'd1);
    repeat (3) @(negedge clk);
    check("len257_no_writes", 32'(wr_addr_log.size() - base), 32'd0);

    // ---- valid session after error ----
    base = wr_addr_log.size();
    pulse_start();
    check("err_cleared", 32'(error), 32'd0);
    send_byte(8'h01, 1'b0);
    send_byte(8'h00, 1'b0);
    send_word(32'hDEAD_BEEF, 1'b0);
    check("len1_data", mem_wr_data, 32'hDEAD_BEEF);
    check("len1_addr", mem_wr_addr, 32'h0);
    wait_idle("len1_idle");
    check("len1_error_low", 32'(error), 32'd0);
    check("len1_wr_count",  32'(wr_addr_log.size() - base), 32'd1);

    // ---- full depth with random words ----
    for (int i = 0; i < DEPTH; i++) exp_words[i] = $urandom;
    base = wr_addr_log.size(); done_base = done_cnt;
    pulse_start();
    send_byte(8'h00, 1'b0);
    send_byte(8'h01, 1'b0);
    for (int i = 0; i < DEPTH; i++) send_word(exp_words[i], 1'b0);
    wait_idle("full_idle");
    check("full_wr_count",  32'(wr_addr_log.size() - base), 32'(DEPTH));
    check("full_last_addr", wr_addr_log[wr_addr_log.size() - 1], 32'h3FC);
    mism = 0;
    for (int i = 0; i < DEPTH; i++) begin
      if (base + i >= wr_addr_log.size()) mism++;
      else if (wr_data_log[base + i] !== exp_words[i] ||
               wr_addr_log[base + i] !== 32'(i * 4)) mism++;
    end
    check("full_scoreboard", 32'(mism), 32'd0);
    check("full_done_once",  32'(done_cnt - done_base), 32'd1);
    check("full_error_low",  32'(error), 32'd0);

    // ---- reset mid-word ----
    base = wr_addr_log.size();
    pulse_start();
    send_byte(8'h02, 1'b0);
    send_byte(8'h00, 1'b0);
    send_word(32'h1111_2222, 1'b0);
    send_byte(8'hAA, 1'b0);
    send_byte(8'hBB, 1'b0);
    #2 rstN = 1'b0;
    #1;
    check("midrst_cpu_rstN", 32'(cpu_rstN),   32'd1);
    check("midrst_busy",     32'(busy),       32'd0);
    check("midrst_ready",    32'(byte_ready), 32'd0);
    check("midrst_addr",     mem_wr_addr,     32'h0);
    check("midrst_data",     mem_wr_data,     32'h0);
    @(negedge clk);
    rstN = 1'b1;
    repeat (2) @(negedge clk);
    check("midrst_one_write", 32'(wr_addr_log.size() - base), 32'd1);

    // ---- start pulses while busy ----
    base = wr_addr_log.size(); done_base = done_cnt;
    pulse_start();
    send_byte(8'h02, 1'b0);
    start = 1'b1;
    send_byte(8'h00, 1'b0);  // start high during LEN
    start = 1'b0;
    send_byte(8'h78, 1'b0);
    start = 1'b1;
    send_byte(8'h56, 1'b0);  // start high during WORD
    start = 1'b0;
    send_byte(8'h34, 1'b0);
    send_byte(8'h12, 1'b0);
    pulse_start();           // start high during WRITE
    send_word(32'hCAFE_F00D, 1'b0);
    wait_idle("sb_idle");
    check("sb_wr_count", 32'(wr_addr_log.size() - base), 32'd2);
    check("sb_data0",    wr_data_log[base],     32'h1234_5678);
    check("sb_addr1",    wr_addr_log[base + 1], 32'h4);
    check("sb_data1",    wr_data_log[base + 1], 32'hCAFE_F00D);
    check("sb_done_once", 32'(done_cnt - done_base), 32'd1);

    // ---- invariants gathered over the whole run ----
    check("cpu_rstN_during_write", 32'(cpu_viol),   32'd0);
    check("ready_during_write",    32'(ready_viol), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
